// File: rtl/osc_tick_pkg.sv
// Shared types, defaults and sizing helpers for the oscillator tick generator.
// Imported by osc_tick_ch and osc_tick_gen.
package osc_tick_pkg;

    typedef enum logic {
        ST_SETTLE,
        ST_RUN
    } state_t;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_DIV_W         = 16;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_DIV           = 50;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int settle_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Channel-select width, max(1, clog2(n)).
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/osc_tick_ch.sv
// One tick channel: divisor, pending divisor, down-counter, active flag, TICK.
// Ports: clk, resetn (sync, active-low), load/en/div (config), sync, run,
//        tick (registered one-cycle strobe), active (channel enabled).
module osc_tick_ch
    import osc_tick_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             sync,
    input  logic             run,
    output logic             tick,
    output logic             active
);

    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] div_pend;
    logic             pend_vld;
    logic [DIV_W-1:0] cnt;

    logic [DIV_W-1:0] n_div;
    logic [DIV_W-1:0] n_pend;
    logic             n_pv;
    logic [DIV_W-1:0] n_cnt;
    logic             n_act;
    logic             term;

    // Reload value D_eff-1, with a divisor of 0 treated as 1.
    function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - DIV_W'(1);
    endfunction

    always_comb begin
        n_div  = div_cur;
        n_pend = div_pend;
        n_pv   = pend_vld;
        n_cnt  = cnt;
        n_act  = active;
        term   = active && (cnt == '0);

        // Terminal count: the period just ended, so a pending divisor
        // can be adopted without shortening or stretching any tick gap.
        if (term) begin
            n_div = pend_vld ? div_pend : div_cur;
            n_pv  = 1'b0;
            n_cnt = reload(n_div);
        end else if (active) begin
            n_cnt = cnt - DIV_W'(1);
        end

        if (load && run) begin
            if (!en) begin
                n_act = 1'b0;
                n_div = div;
                n_pv  = 1'b0;
                n_cnt = '0;
            end else if (!active || term) begin
                // Fresh start, or the reload point is this very cycle.
                n_act = 1'b1;
                n_div = div;
                n_pv  = 1'b0;
                n_cnt = reload(div);
            end else begin
                n_pend = div;
                n_pv   = 1'b1;
            end
        end

        // Sync sees the post-config divisor and enable.
        if (sync && run && n_act) begin
            if (n_pv) begin
                n_div = n_pend;
            end
            n_pv  = 1'b0;
            n_cnt = reload(n_div);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cur  <= DIV_W'(DEFAULT_DIV);
            div_pend <= '0;
            pend_vld <= 1'b0;
            cnt      <= '0;
            active   <= 1'b0;
            tick     <= 1'b0;
        end else begin
            div_cur  <= n_div;
            div_pend <= n_pend;
            pend_vld <= n_pv;
            cnt      <= n_cnt;
            active   <= n_act;
            tick     <= n_act && (n_cnt == '0);
        end
    end

endmodule

// File: rtl/osc_tick_gen.sv
// RC-oscillator tick generator: settle window, then NUM_CH programmable ticks.
// Ports: CLK, RESETN, CFG_VALID/READY/CH/DIV/EN, SYNC_ALL, OSC_READY, TICK, CH_ACTIVE.
module osc_tick_gen
    import osc_tick_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int DIV_W         = DEF_DIV_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DEFAULT_DIV   = DEF_DIV,
    localparam int CH_W         = ch_w(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [DIV_W-1:0]  CFG_DIV,
    input  logic              CFG_EN,
    input  logic              SYNC_ALL,
    output logic              OSC_READY,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] CH_ACTIVE
);

    localparam int SW = settle_w(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [SW-1:0]     scnt;
    logic              run;
    logic              hs;
    logic [NUM_CH-1:0] load;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= ST_SETTLE;
            scnt  <= '0;
        end else begin
            unique case (state)
                ST_SETTLE: begin
                    if (scnt == SETTLE_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        scnt <= scnt + SW'(1);
                    end
                end
                ST_RUN: state <= ST_RUN;
            endcase
        end
    end

    assign run       = (state == ST_RUN);
    assign OSC_READY = run;
    assign CFG_READY = run;
    assign hs        = CFG_VALID && run;

    // Out-of-range CFG_CH matches no channel, so the handshake is a no-op.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = hs && (CFG_CH == CH_W'(i));

        osc_tick_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (CLK),
            .resetn (RESETN),
            .load   (load[i]),
            .en     (CFG_EN),
            .div    (CFG_DIV),
            .sync   (SYNC_ALL),
            .run    (run),
            .tick   (TICK[i]),
            .active (CH_ACTIVE[i])
        );
    end

endmodule

// File: tb/tb_osc_tick_gen.sv
// Self-checking bench for osc_tick_gen: directed tables/sequences plus
// random stimulus against a tick-time reference model.
module tb_osc_tick_gen;

    localparam int NCH    = 4;
    localparam int SETTLE = 1024;
    localparam int DEFD   = 50;

    logic        clk = 1'b0;
    logic        rstn, cv, cen, sync;
    logic [1:0]  cch;
    logic [15:0] cdiv;
    logic        cr, rdy;
    logic [3:0]  tick, act;

    logic        b_rstn, b_cv, b_cen, b_sync;
    logic [1:0]  b_ch;
    logic [7:0]  b_div;
    logic        b_cr, b_rdy;
    logic [2:0]  b_tick, b_act;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    osc_tick_gen #(
        .NUM_CH(NCH), .DIV_W(16), .SETTLE_CYCLES(SETTLE), .DEFAULT_DIV(DEFD)
    ) dut (
        .CLK(clk), .RESETN(rstn), .CFG_VALID(cv), .CFG_READY(cr),
        .CFG_CH(cch), .CFG_DIV(cdiv), .CFG_EN(cen), .SYNC_ALL(sync),
        .OSC_READY(rdy), .TICK(tick), .CH_ACTIVE(act)
    );

    osc_tick_gen #(
        .NUM_CH(3), .DIV_W(8), .SETTLE_CYCLES(1), .DEFAULT_DIV(2)
    ) dut_b (
        .CLK(clk), .RESETN(b_rstn), .CFG_VALID(b_cv), .CFG_READY(b_cr),
        .CFG_CH(b_ch), .CFG_DIV(b_div), .CFG_EN(b_cen), .SYNC_ALL(b_sync),
        .OSC_READY(b_rdy), .TICK(b_tick), .CH_ACTIVE(b_act)
    );

    // Reference model: absolute cycle of each channel's next tick.
    bit m_run;
    int m_seen;
    bit m_act[NCH];
    int m_div[NCH];
    bit m_pv[NCH];
    int m_pend[NCH];
    int m_next[NCH];
    bit m_hit[NCH];

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_edge();
        int c;
        int p;
        int k;
        c = cyc;
        cyc = cyc + 1;
        if (!rstn) begin
            m_run = 0;
            m_seen = 0;
            for (int i = 0; i < NCH; i++) begin
                m_act[i] = 0;
                m_div[i] = DEFD;
                m_pv[i] = 0;
            end
            return;
        end
        if (!m_run) begin
            m_seen++;
            if (m_seen == SETTLE) m_run = 1;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            m_hit[i] = m_act[i] && (m_next[i] == c);
            if (m_hit[i]) begin
                p = m_pv[i] ? m_pend[i] : m_div[i];
                m_div[i] = p;
                m_pv[i] = 0;
                m_next[i] = c + eff(p);
            end
        end
        if (cv && int'(cch) < NCH) begin
            k = int'(cch);
            if (!cen) begin
                m_act[k] = 0;
                m_div[k] = int'(cdiv);
                m_pv[k] = 0;
            end else if (!m_act[k] || m_hit[k]) begin
                m_act[k] = 1;
                m_div[k] = int'(cdiv);
                m_pv[k] = 0;
                m_next[k] = c + eff(int'(cdiv));
            end else begin
                m_pend[k] = int'(cdiv);
                m_pv[k] = 1;
            end
        end
        if (sync) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_act[i]) begin
                    p = m_pv[i] ? m_pend[i] : m_div[i];
                    m_div[i] = p;
                    m_pv[i] = 0;
                    m_next[i] = c + eff(p);
                end
            end
        end
    endtask

    task automatic check_model();
        logic [9:0] exp;
        logic [9:0] got;
        exp = {m_run, m_run, 8'h00};
        for (int i = 0; i < NCH; i++) begin
            exp[4+i] = m_act[i];
            exp[i]   = m_run && m_act[i] && (m_next[i] == cyc);
        end
        got = {rdy, cr, act, tick};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model cyc=%0d got=%b exp=%b", cyc, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic cfg(input int ch, input int d, input bit en);
        cv = 1'b1;
        cch = ch[1:0];
        cdiv = d[15:0];
        cen = en;
        step();
        cv = 1'b0;
    endtask

    task automatic settle_check(input string name);
        int first;
        first = -1;
        for (int k = 1; k <= SETTLE + 2; k++) begin
            // Requests during the settle window must be ignored.
            cv   = (k >= 500 && k < 510);
            cch  = 2'd1;
            cdiv = 16'd3;
            cen  = 1'b1;
            sync = (k == 505);
            step();
            if (rdy && first < 0) first = k;
            if (first < 0 && (tick != 0 || cr != 0 || act != 0)) begin
                chk({name, "_quiet"}, {cr, act, tick}, 0);
            end
        end
        cv = 1'b0;
        sync = 1'b0;
        chk({name, "_ready_at"}, first, SETTLE);
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        en;
        logic        t0;
        logic        a0;
    } vec_t;

    vec_t tbl[17];

    int t0;
    logic [31:0] mask0, mask1;

    initial begin
        tbl[0] = '{v: 1'b1, d: 16'd5, en: 1'b1, t0: 1'b0, a0: 1'b1};
        for (int r = 1; r < 16; r++) begin
            tbl[r] = '{v: 1'b0, d: 16'd0, en: 1'b0,
                       t0: (r == 4 || r == 9 || r == 14), a0: 1'b1};
        end
        tbl[16] = '{v: 1'b1, d: 16'd5, en: 1'b0, t0: 1'b0, a0: 1'b0};

        for (int i = 0; i < NCH; i++) begin
            m_act[i] = 0; m_div[i] = DEFD; m_pv[i] = 0;
            m_pend[i] = 0; m_next[i] = 0; m_hit[i] = 0;
        end
        m_run = 0; m_seen = 0;
        rstn = 1'b0; cv = 1'b0; cen = 1'b0; sync = 1'b0;
        cch = 2'd0; cdiv = 16'd0;
        b_rstn = 1'b0; b_cv = 1'b0; b_cen = 1'b0; b_sync = 1'b0;
        b_ch = 2'd0; b_div = 8'd0;

        // Reset state and settle window.
        step();
        chk("reset_out", {rdy, cr, act, tick}, 0);
        rstn = 1'b1;
        settle_check("settle1");

        // Table: enable ch0 DIV=5, ticks at T+5/10/15, then disable.
        for (int r = 0; r < 17; r++) begin
            cv = tbl[r].v; cch = 2'd0; cdiv = tbl[r].d; cen = tbl[r].en;
            step();
            chk("tbl_tick0", tick[0], tbl[r].t0);
            chk("tbl_act0", act[0], tbl[r].a0);
        end
        cv = 1'b0;

        // Glitch-free rate change 10 -> 3 in the middle of a period.
        t0 = cyc;
        cfg(0, 10, 1);
        mask0 = 0;
        for (int k = 0; k < 30; k++) begin
            if (cyc == t0 + 14) begin
                cv = 1'b1; cch = 2'd0; cdiv = 16'd3; cen = 1'b1;
            end
            step();
            cv = 1'b0;
            if (tick[0]) mask0[cyc - t0] = 1'b1;
        end
        chk("rate_change", mask0, (1 << 10) | (1 << 20) | (1 << 23) |
                                  (1 << 26) | (1 << 29));
        cfg(0, 10, 0);

        // SYNC_ALL realigns out-of-phase channels.
        cfg(0, 4, 1);
        step();
        step();
        cfg(1, 6, 1);
        for (int k = 0; k < 5; k++) step();
        t0 = cyc;
        sync = 1'b1;
        step();
        sync = 1'b0;
        mask0 = 0;
        mask1 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tick[0]) mask0[cyc - t0] = 1'b1;
            if (tick[1]) mask1[cyc - t0] = 1'b1;
        end
        chk("sync_ch0", mask0, (1 << 4) | (1 << 8) | (1 << 12));
        chk("sync_ch1", mask1, (1 << 6) | (1 << 12));

        // DIV=0 and DIV=1 tick every cycle; disable stops at once.
        cfg(2, 0, 1);
        chk("div0_first", tick[2], 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("div0_cont", tick[2], 1);
        end
        cfg(2, 1, 1);
        chk("div1_first", tick[2], 1);
        step();
        chk("div1_cont", tick[2], 1);
        cfg(2, 1, 0);
        chk("dis_tick2", tick[2], 0);
        chk("dis_act2", act[2], 0);

        // Reset with every channel running.
        cfg(2, 7, 1);
        cfg(3, 9, 1);
        for (int k = 0; k < 10; k++) step();
        chk("all_run", act, 4'hf);
        rstn = 1'b0;
        step();
        chk("midreset_out", {rdy, cr, act, tick}, 0);
        rstn = 1'b1;
        settle_check("settle2");
        chk("post_reset_act", act, 0);

        // Minimal settle and out-of-range channel on a 3-channel instance.
        step();
        chk("b_reset_rdy", b_rdy, 0);
        b_rstn = 1'b1;
        step();
        chk("b_settle1_rdy", {b_rdy, b_cr}, 2'b11);
        b_cv = 1'b1; b_ch = 2'd3; b_div = 8'd1; b_cen = 1'b1;
        step();
        b_cv = 1'b0;
        step();
        chk("b_oob", {b_act, b_tick}, 0);
        b_cv = 1'b1; b_ch = 2'd1; b_div = 8'd2;
        step();
        b_cv = 1'b0;
        chk("b_ch1_act", {b_act, b_tick}, {3'b010, 3'b000});
        step();
        chk("b_ch1_tick", b_tick, 3'b010);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cv = ($urandom_range(0, 5) == 0);
            cch = 2'($urandom_range(0, 3));
            cdiv = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 60))
                                               : 16'($urandom_range(0, 8));
            cen = ($urandom_range(0, 3) != 0);
            sync = ($urandom_range(0, 40) == 0);
            step();
        end
        cv = 1'b0;
        sync = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
